dds_sweep_ctrl: RTL

Sequencer for the DDS sine lookup ROM. It holds a frequency-sweep configuration and runs a phase accumulator. It drives the ROM's enable and address each cycle and re-aligns the ROM's 1-cycle registered output into a valid-qualified waveform stream. It supports single-shot or repeating linear chirps and sits between the software-facing config interface and the sine ROM.

---
 rtl/dds_pkg.sv | 24 ++
 rtl/dds_phase_acc.sv | 42 ++++
 rtl/dds_sweep_ctrl.sv | 154 +++++++++++++++
 3 files changed

// File: rtl/dds_pkg.sv
// Shared types for the DDS sweep sequencer: FSM states and the
// latched sweep configuration bundle.
package dds_pkg;

   localparam int DDS_PHASE_W = 32;
   localparam int DDS_WIDE    = 12;
   localparam int DDS_CNT     = 8;
   localparam int DDS_STEP_W  = 16;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ARMED = 2'd1,
      RUN   = 2'd2
   } state_t;

   typedef struct packed {
      logic [DDS_PHASE_W-1:0] fstart;
      logic [DDS_PHASE_W-1:0] fstep;
      logic [DDS_STEP_W-1:0]  steps;
      logic [DDS_STEP_W-1:0]  dwell;
      logic                   rpt;
   } cfg_t;

endpackage

// File: rtl/dds_phase_acc.sv
// Phase accumulator with tuning-word register.
// Ports: clk, rst_n; clear/advance act on phase, load/add_step on ftw;
// load_val, step are the ftw operands; addr is the top WIDE phase bits.
module dds_phase_acc
   import dds_pkg::*;
#(
   parameter int PHASE_W = DDS_PHASE_W,
   parameter int WIDE    = DDS_WIDE
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               clear,
   input  logic               advance,
   input  logic               load,
   input  logic               add_step,
   input  logic [PHASE_W-1:0] load_val,
   input  logic [PHASE_W-1:0] step,
   output logic [WIDE-1:0]    addr
);

   logic [PHASE_W-1:0] phase;
   logic [PHASE_W-1:0] ftw;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         phase <= '0;
         ftw   <= '0;
      end else begin
         if (clear)
            phase <= '0;
         else if (advance)
            phase <= phase + ftw;
         if (load)
            ftw <= load_val;
         else if (add_step)
            ftw <= ftw + step;
      end
   end

   assign addr = phase[PHASE_W-1 -: WIDE];

endmodule

// File: rtl/dds_sweep_ctrl.sv
// DDS sweep sequencer: config latch, sweep FSM, dwell/segment counters,
// ROM drive and realignment of the ROM's registered output.
// Ports: clk, rst_n; cfg_* config handshake; start/stop control;
// busy/done status; rom_enable/rom_addr/rom_data ROM side;
// wave_o/wave_valid output stream.
module dds_sweep_ctrl
   import dds_pkg::*;
#(
   parameter int PHASE_W = DDS_PHASE_W,
   parameter int WIDE    = DDS_WIDE,
   parameter int CNT     = DDS_CNT,
   parameter int STEP_W  = DDS_STEP_W
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               cfg_valid,
   output logic               cfg_ready,
   input  logic [PHASE_W-1:0] cfg_fstart,
   input  logic [PHASE_W-1:0] cfg_fstep,
   input  logic [STEP_W-1:0]  cfg_steps,
   input  logic [STEP_W-1:0]  cfg_dwell,
   input  logic               cfg_repeat,
   input  logic               start,
   input  logic               stop,
   output logic               busy,
   output logic               done,
   output logic               rom_enable,
   output logic [WIDE-1:0]    rom_addr,
   input  logic [CNT-1:0]     rom_data,
   output logic [CNT-1:0]     wave_o,
   output logic               wave_valid
);

   state_t state;
   state_t state_nx;
   cfg_t   cfg;

   logic [STEP_W-1:0] seg_cnt;
   logic [STEP_W-1:0] dwell_cnt;
   logic [STEP_W-1:0] dwell_max;
   logic [WIDE-1:0]   acc_addr;

   logic hs;
   logic seg_end;
   logic last_seg;
   logic ph_clr;
   logic ph_adv;
   logic ftw_load;
   logic ftw_add;
   logic done_nx;

   assign hs        = cfg_valid & cfg_ready;
   // A dwell of 0 behaves like a dwell of 1.
   assign dwell_max = (cfg.dwell == '0) ? '0 : cfg.dwell - STEP_W'(1);
   assign seg_end   = (dwell_cnt == dwell_max);
   assign last_seg  = (seg_cnt == cfg.steps);

   always_comb begin
      state_nx   = state;
      cfg_ready  = 1'b0;
      busy       = 1'b0;
      rom_enable = 1'b0;
      ph_clr     = 1'b0;
      ph_adv     = 1'b0;
      ftw_load   = 1'b0;
      ftw_add    = 1'b0;
      done_nx    = 1'b0;
      unique case (state)
         IDLE: begin
            cfg_ready = 1'b1;
            if (cfg_valid)
               state_nx = ARMED;
         end
         ARMED: begin
            cfg_ready = 1'b1;
            if (start && !stop) begin
               state_nx = RUN;
               ph_clr   = 1'b1;
               ftw_load = 1'b1;
            end
         end
         RUN: begin
            busy       = 1'b1;
            rom_enable = 1'b1;
            ph_adv     = 1'b1;
            if (stop) begin
               state_nx = ARMED;
            end else if (seg_end) begin
               if (!last_seg) begin
                  ftw_add = 1'b1;
               end else if (cfg.rpt) begin
                  // Phase keeps running across the loop.
                  ftw_load = 1'b1;
               end else begin
                  state_nx = ARMED;
                  done_nx  = 1'b1;
               end
            end
         end
         default: state_nx = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state      <= IDLE;
         cfg        <= '0;
         seg_cnt    <= '0;
         dwell_cnt  <= '0;
         done       <= 1'b0;
         wave_valid <= 1'b0;
      end else begin
         state      <= state_nx;
         done       <= done_nx;
         wave_valid <= rom_enable;
         if (hs)
            cfg <= '{fstart: cfg_fstart,
                     fstep:  cfg_fstep,
                     steps:  cfg_steps,
                     dwell:  cfg_dwell,
                     rpt:    cfg_repeat};
         if (ph_clr) begin
            seg_cnt   <= '0;
            dwell_cnt <= '0;
         end else if (state == RUN && !stop) begin
            if (seg_end) begin
               dwell_cnt <= '0;
               seg_cnt   <= last_seg ? '0 : seg_cnt + STEP_W'(1);
            end else begin
               dwell_cnt <= dwell_cnt + STEP_W'(1);
            end
         end
      end
   end

   dds_phase_acc #(
      .PHASE_W (PHASE_W),
      .WIDE    (WIDE)
   ) u_acc (
      .clk      (clk),
      .rst_n    (rst_n),
      .clear    (ph_clr),
      .advance  (ph_adv),
      .load     (ftw_load),
      .add_step (ftw_add),
      .load_val (cfg.fstart),
      .step     (cfg.fstep),
      .addr     (acc_addr)
   );

   assign rom_addr = rom_enable ? acc_addr : '0;
   assign wave_o   = wave_valid ? rom_data : '0;

endmodule
